// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and grant encodings.
// Imported by the arbiter, its round-robin picker and the testbench.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    G_CORE = 1'b0,
    G_DBG  = 1'b1
  } grant_e;

  function automatic grant_e other_grant(input grant_e g);
    return (g == G_CORE) ? G_DBG : G_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus interfaces for the data-memory arbiter: a requester port (core or debug)
// and the single-port memory side.
interface dmem_req_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          stall;

  modport master (output req, we, addr, wdata, input rdata, ack, stall);
  modport slave  (input req, we, addr, wdata, output rdata, ack, stall);
endinterface

interface dmem_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between core and debug requesters; on a tie the
// requester that did not win last time is chosen.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic   core_req_i,
  input  logic   dbg_req_i,
  input  grant_e last_grant_i,
  output logic   valid_o,
  output grant_e grant_o
);

  always_comb begin
    valid_o = core_req_i | dbg_req_i;
    grant_o = G_CORE;
    if (core_req_i && dbg_req_i) begin
      grant_o = other_grant(last_grant_i);
    end else if (dbg_req_i) begin
      grant_o = G_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core MEM stage and a debug
// port: round-robin grant, fixed-latency access sequencing, core stall.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic      clk,
  input  logic      reset,
  dmem_req_if.slave core,
  dmem_req_if.slave dbg,
  dmem_mem_if.master mem
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic   pick_valid;
  grant_e pick_grant;
  logic   core_ack, dbg_ack;

  rr_arbiter2 u_rr (
    .core_req_i   (core.req),
    .dbg_req_i    (dbg.req),
    .last_grant_i (grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  // grant_q doubles as last_grant; resetting it to DBG lets the core win the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= G_DBG;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case infers a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          cnt_d   = '0;
          state_d = S_ACCESS;
          if (pick_grant == G_DBG) begin
            we_d    = dbg.we;
            addr_d  = dbg.addr;
            wdata_d = dbg.wdata;
          end else begin
            we_d    = core.we;
            addr_d  = core.addr;
            wdata_d = core.wdata;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (grant_q == G_DBG) dbg_rdata_d  = mem.rdata;
            else                  core_rdata_d = mem.rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign core_ack = (state_q == S_RESP) && (grant_q == G_CORE);
  assign dbg_ack  = (state_q == S_RESP) && (grant_q == G_DBG);

  assign mem.en    = (state_q == S_ACCESS);
  assign mem.we    = (state_q == S_ACCESS) && we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  assign core.ack   = core_ack;
  assign core.rdata = core_rdata_q;
  assign core.stall = core.req & ~core_ack;
  assign dbg.ack    = dbg_ack;
  assign dbg.rdata  = dbg_rdata_q;
  assign dbg.stall  = dbg.req & ~dbg_ack;

endmodule
